// File: rtl/warp_scheduler.sv
// warp_scheduler: NUM_WARPS kernel contexts, shared round-robin fetch, round-robin issue.
// Optional warp kill support is enabled by defining WARP_SCHED_KILL_EN.
module warp_scheduler #(
    parameter  int NUM_WARPS = 4,
    parameter  int ADDR_W    = 32,
    parameter  int LEN_W     = 16,
    parameter  int INST_W    = 32,
    localparam int WID_W     = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 launch_valid,
    input  logic [WID_W-1:0]     launch_warp,
    input  logic [ADDR_W-1:0]    launch_addr,
    input  logic [LEN_W-1:0]     launch_len,
    output logic                 launch_ready,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [INST_W-1:0]    mem_rdata,
    output logic                 lane_execute,
    output logic [INST_W-1:0]    lane_instruction,
    output logic [WID_W-1:0]     lane_warp,
    input  logic                 lane_ready,
`ifdef WARP_SCHED_KILL_EN
    input  logic                 kill_valid,
    input  logic [WID_W-1:0]     kill_warp,
`endif
    output logic [NUM_WARPS-1:0] warp_done,
    output logic [NUM_WARPS-1:0] busy,
    output logic                 err_spurious
);

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fstate_t;

    fstate_t              fstate;
    logic [WID_W-1:0]     fw;
    logic [WID_W-1:0]     fetch_ptr;
    logic [WID_W-1:0]     issue_ptr;
    logic [ADDR_W-1:0]    pc         [NUM_WARPS];
    logic [LEN_W-1:0]     fetch_left [NUM_WARPS];
    logic [LEN_W-1:0]     issue_left [NUM_WARPS];
    logic [INST_W-1:0]    buf_d      [NUM_WARPS];
    logic [NUM_WARPS-1:0] buf_v;
    logic [NUM_WARPS-1:0] killed;

    logic                 kill_fire;
    logic [WID_W-1:0]     kill_id;

`ifdef WARP_SCHED_KILL_EN
    assign kill_fire = kill_valid && busy[kill_warp];
    assign kill_id   = kill_warp;
`else
    assign kill_fire = 1'b0;
    assign kill_id   = '0;
`endif

    assign launch_ready = !busy[launch_warp];

    function automatic logic [WID_W-1:0] nxt(input logic [WID_W-1:0] w);
        nxt = (int'(w) == NUM_WARPS - 1) ? '0 : w + WID_W'(1);
    endfunction

    // Returns {found, id}; scanning downwards lets the nearest hit win.
    function automatic logic [WID_W:0] rr_pick(
        input logic [NUM_WARPS-1:0] req,
        input logic [WID_W-1:0]     ptr
    );
        int idx;
        rr_pick = '0;
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_WARPS;
            if (req[idx]) rr_pick = {1'b1, WID_W'(idx)};
        end
    endfunction

    logic [NUM_WARPS-1:0] fetch_req;
    logic [NUM_WARPS-1:0] issue_req;
    logic [WID_W:0]       fetch_sel;
    logic [WID_W:0]       issue_sel;
    logic [WID_W-1:0]     issue_base;
    logic                 xfer;

    always_comb begin
        fetch_req = '0;
        issue_req = '0;
        xfer      = lane_execute && lane_ready;
        for (int i = 0; i < NUM_WARPS; i++) begin
            fetch_req[i] = busy[i] && !killed[i] &&
                           fetch_left[i] != '0 && !buf_v[i];
            issue_req[i] = buf_v[i] && !killed[i];
        end
        // The buffer being drained this cycle is not a candidate for the next slot.
        if (xfer) issue_req[lane_warp] = 1'b0;
        if (kill_fire) begin
            issue_req[kill_id] = 1'b0;
            fetch_req[kill_id] = 1'b0;
        end
        issue_base = xfer ? nxt(lane_warp) : issue_ptr;
        fetch_sel  = rr_pick(fetch_req, fetch_ptr);
        issue_sel  = rr_pick(issue_req, issue_base);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fstate           <= F_IDLE;
            fw               <= '0;
            fetch_ptr        <= '0;
            issue_ptr        <= '0;
            mem_req          <= 1'b0;
            mem_addr         <= '0;
            lane_execute     <= 1'b0;
            lane_instruction <= '0;
            lane_warp        <= '0;
            warp_done        <= '0;
            busy             <= '0;
            err_spurious     <= 1'b0;
            buf_v            <= '0;
            killed           <= '0;
            for (int i = 0; i < NUM_WARPS; i++) begin
                pc[i]         <= '0;
                fetch_left[i] <= '0;
                issue_left[i] <= '0;
                buf_d[i]      <= '0;
            end
        end else begin
            warp_done <= '0;

            if (launch_valid && launch_ready) begin
                busy[launch_warp]       <= 1'b1;
                pc[launch_warp]         <= launch_addr;
                fetch_left[launch_warp] <= launch_len;
                issue_left[launch_warp] <= launch_len;
                buf_v[launch_warp]      <= 1'b0;
                killed[launch_warp]     <= 1'b0;
            end

            unique case (fstate)
                F_IDLE: begin
                    if (mem_rvalid) err_spurious <= 1'b1;
                    if (fetch_sel[WID_W]) begin
                        fw       <= fetch_sel[WID_W-1:0];
                        mem_req  <= 1'b1;
                        mem_addr <= pc[fetch_sel[WID_W-1:0]];
                        fstate   <= F_REQ;
                    end
                end
                F_REQ: begin
                    if (mem_rvalid) err_spurious <= 1'b1;
                    if (mem_gnt) begin
                        mem_req   <= 1'b0;
                        pc[fw]    <= pc[fw] + ADDR_W'(4);
                        if (fetch_left[fw] != '0)
                            fetch_left[fw] <= fetch_left[fw] - LEN_W'(1);
                        fetch_ptr <= nxt(fw);
                        fstate    <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (mem_rvalid) begin
                        if (!killed[fw]) begin
                            buf_v[fw] <= 1'b1;
                            buf_d[fw] <= mem_rdata;
                        end
                        fstate <= F_IDLE;
                    end
                end
                default: fstate <= F_IDLE;
            endcase

            if (xfer) begin
                buf_v[lane_warp]      <= 1'b0;
                issue_left[lane_warp] <= issue_left[lane_warp] - LEN_W'(1);
                issue_ptr             <= nxt(lane_warp);
                if (issue_left[lane_warp] == LEN_W'(1)) begin
                    warp_done[lane_warp] <= 1'b1;
                    busy[lane_warp]      <= 1'b0;
                end
            end

            if (!lane_execute || lane_ready) begin
                lane_execute <= issue_sel[WID_W];
                if (issue_sel[WID_W]) begin
                    lane_warp        <= issue_sel[WID_W-1:0];
                    lane_instruction <= buf_d[issue_sel[WID_W-1:0]];
                end
            end

            // Zero-length kernels finish here; killed warps retire once no fetch is in flight.
            for (int i = 0; i < NUM_WARPS; i++) begin
                if (killed[i]) begin
                    if (!(fstate != F_IDLE && int'(fw) == i)) begin
                        killed[i] <= 1'b0;
                        if (busy[i]) busy[i] <= 1'b0;
                    end
                end else if (busy[i] && issue_left[i] == '0) begin
                    busy[i]      <= 1'b0;
                    warp_done[i] <= 1'b1;
                end
            end

            if (kill_fire) begin
                killed[kill_id]     <= 1'b1;
                buf_v[kill_id]      <= 1'b0;
                fetch_left[kill_id] <= '0;
                issue_left[kill_id] <= '0;
                warp_done[kill_id]  <= 1'b0;
                if (lane_execute && lane_warp == kill_id && !xfer)
                    lane_execute <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_warp_scheduler.sv
// tb_warp_scheduler: random launches, grant/return delays and lane stalls checked
// against a per-warp model of expected instruction streams and completion cycles.
module tb_warp_scheduler;

    localparam int NW = 4;
    localparam int AW = 32;
    localparam int LW = 16;
    localparam int IW = 32;
    localparam int WW = 2;
    localparam longint NEVER = 64'd1 << 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          launch_valid;
    logic [WW-1:0] launch_warp;
    logic [AW-1:0] launch_addr;
    logic [LW-1:0] launch_len;
    logic          launch_ready;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_gnt;
    logic          mem_rvalid;
    logic [IW-1:0] mem_rdata;
    logic          lane_execute;
    logic [IW-1:0] lane_instruction;
    logic [WW-1:0] lane_warp;
    logic          lane_ready;
    logic [NW-1:0] warp_done;
    logic [NW-1:0] busy;
    logic          err_spurious;

    warp_scheduler #(
        .NUM_WARPS(NW), .ADDR_W(AW), .LEN_W(LW), .INST_W(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .launch_valid(launch_valid), .launch_warp(launch_warp),
        .launch_addr(launch_addr), .launch_len(launch_len),
        .launch_ready(launch_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .lane_execute(lane_execute), .lane_instruction(lane_instruction),
        .lane_warp(lane_warp), .lane_ready(lane_ready),
        .warp_done(warp_done), .busy(busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Model: each launched warp owns the stream mem_word(base + 4k), k < len.
    longint        t = 0;
    bit            m_act  [NW];
    logic [31:0]   m_base [NW];
    int            m_len  [NW];
    int            m_iss  [NW];
    longint        m_acc  [NW];
    longint        m_done [NW];
    int            n_done [NW];
    bit            exp_err;

    bit            l_valid;
    int            l_warp;
    logic [31:0]   l_addr;
    int            l_len;
    bit            l_acc;

    int            gnt_pct;
    int            rdy_pct;
    int            rv_max;
    bit            inj_rv;
    bit            pend;
    logic [31:0]   pend_addr;
    int            pend_dly;
    longint        last_rv_t;

    bit            p_exec, p_rdy, p_req, p_gnt;
    logic [31:0]   p_instr, p_addr;
    logic [WW-1:0] p_warp;

    int            n_xfer;
    int            n_req_cyc;
    int            xfer_log[$];
    logic [31:0]   gnt_log[$];

    function automatic bit exp_busy(input int w);
        return m_act[w] && t > m_acc[w] && t < m_done[w];
    endfunction

    function automatic bit any_open();
        for (int w = 0; w < NW; w++)
            if (m_act[w] && m_done[w] >= t) return 1'b1;
        return pend;
    endfunction

    task automatic step();
        logic [NW-1:0] eb, ed;
        int w;
        bit did_inj;
        @(negedge clk);
        t++;
        for (int i = 0; i < NW; i++) begin
            eb[i] = exp_busy(i);
            ed[i] = m_act[i] && t == m_done[i];
            if (warp_done[i]) n_done[i]++;
        end
        check("busy", busy, eb);
        check("warp_done", warp_done, ed);
        check("err_spurious", err_spurious, exp_err);
        if (p_exec && !p_rdy) begin
            check("hold_exec", lane_execute, 1);
            check("hold_instr", lane_instruction, p_instr);
            check("hold_warp", lane_warp, p_warp);
        end
        if (lane_execute) begin
            w = int'(lane_warp);
            check("issue_owner_busy", eb[w], 1);
            check("issue_in_range", m_iss[w] < m_len[w], 1);
            check("issue_instr", lane_instruction,
                  mem_word(m_base[w] + 32'(4 * m_iss[w])));
        end
        if (p_req && !p_gnt) begin
            check("hold_req", mem_req, 1);
            check("hold_addr", mem_addr, p_addr);
        end
        if (mem_req) n_req_cyc++;

        lane_ready = $urandom_range(99) < rdy_pct;
        mem_gnt    = mem_req && ($urandom_range(99) < gnt_pct);
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        did_inj    = 1'b0;
        if (pend) begin
            if (pend_dly == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = mem_word(pend_addr);
                pend       = 1'b0;
                last_rv_t  = t;
            end else pend_dly--;
        end else if (inj_rv && !mem_req) begin
            mem_rvalid = 1'b1;
            did_inj    = 1'b1;
        end
        launch_valid = l_valid;
        launch_warp  = WW'(l_warp);
        launch_addr  = l_addr;
        launch_len   = LW'(l_len);
        #1;
        check("launch_ready", launch_ready, !exp_busy(l_warp));

        l_acc = l_valid && !exp_busy(l_warp);
        if (lane_execute && lane_ready) begin
            w = int'(lane_warp);
            xfer_log.push_back(w);
            n_xfer++;
            m_iss[w]++;
            if (m_iss[w] == m_len[w]) m_done[w] = t + 1;
        end
        if (mem_gnt) begin
            pend      = 1'b1;
            pend_addr = mem_addr;
            pend_dly  = $urandom_range(rv_max);
            gnt_log.push_back(mem_addr);
        end
        if (l_acc) begin
            m_act[l_warp]  = 1'b1;
            m_base[l_warp] = l_addr;
            m_len[l_warp]  = l_len;
            m_iss[l_warp]  = 0;
            m_acc[l_warp]  = t;
            m_done[l_warp] = (l_len == 0) ? t + 2 : NEVER;
            l_valid        = 1'b0;
        end
        if (did_inj) exp_err = 1'b1;
        p_exec  = lane_execute;
        p_rdy   = lane_ready;
        p_instr = lane_instruction;
        p_warp  = lane_warp;
        p_req   = mem_req;
        p_gnt   = mem_gnt;
        p_addr  = mem_addr;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        launch_valid = 1'b0;
        launch_warp  = '0;
        launch_addr  = '0;
        launch_len   = '0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;
        lane_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_launch_ready", launch_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_lane_execute", lane_execute, 0);
        check("rst_lane_instruction", lane_instruction, 0);
        check("rst_lane_warp", lane_warp, 0);
        check("rst_warp_done", warp_done, 0);
        check("rst_busy", busy, 0);
        check("rst_err_spurious", err_spurious, 0);
        rst     = 1'b0;
        exp_err = 1'b0;
        pend    = 1'b0;
        l_valid = 1'b0;
        inj_rv  = 1'b0;
        p_exec  = 1'b0;
        p_req   = 1'b0;
        for (int i = 0; i < NW; i++) m_act[i] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (any_open() && k < budget) begin
            step();
            k++;
        end
        check("drain_in_budget", k < budget, 1);
        step();
    endtask

    task automatic launch(input int w, input logic [31:0] a, input int len);
        l_valid = 1'b1;
        l_warp  = w;
        l_addr  = a;
        l_len   = len;
    endtask

    task automatic clear_logs();
        xfer_log.delete();
        gnt_log.delete();
        n_xfer = 0;
        for (int i = 0; i < NW; i++) n_done[i] = 0;
    endtask

    initial begin
        int k;
        int n0;
        gnt_pct = 100;
        rdy_pct = 100;
        rv_max  = 0;
        l_warp  = 0;
        l_addr  = '0;
        l_len   = 0;
        do_reset();

        // Single warp, three instructions, immediate grant/return.
        clear_logs();
        launch(0, 32'h100, 3);
        step();
        step();
        check("t1_req_n1", mem_req, 0);
        step();
        check("t1_req_n2", mem_req, 1);
        last_rv_t = -1;
        k = 0;
        while (last_rv_t < 0 && k < 20) begin step(); k++; end
        check("t1_rvalid_seen", last_rv_t >= 0, 1);
        step();
        check("t1_exec_m1", lane_execute, 0);
        step();
        check("t1_exec_m2", lane_execute, 1);
        drain(100);
        check("t1_gnt_count", gnt_log.size(), 3);
        if (gnt_log.size() == 3) begin
            check("t1_addr0", gnt_log[0], 32'h100);
            check("t1_addr1", gnt_log[1], 32'h104);
            check("t1_addr2", gnt_log[2], 32'h108);
        end
        check("t1_xfers", n_xfer, 3);
        check("t1_done0", n_done[0], 1);
        check("t1_busy0", busy[0], 0);

        // Two warps interleave fetch and issue.
        clear_logs();
        launch(0, 32'h200, 2);
        step();
        launch(1, 32'h300, 2);
        step();
        drain(100);
        check("t2_xfers", xfer_log.size(), 4);
        if (xfer_log.size() == 4)
            check("t2_order", {xfer_log[0][3:0], xfer_log[1][3:0],
                               xfer_log[2][3:0], xfer_log[3][3:0]}, 16'h0101);
        check("t2_done0", n_done[0], 1);
        check("t2_done1", n_done[1], 1);

        // Lane stall holds the pending issue.
        clear_logs();
        rdy_pct = 0;
        launch(3, 32'h400, 1);
        k = 0;
        while (!lane_execute && k < 20) begin step(); k++; end
        check("t3_exec_seen", lane_execute, 1);
        n0 = 0;
        repeat (5) begin
            step();
            if (lane_execute) n0++;
        end
        check("t3_held_cycles", n0, 5);
        rdy_pct = 100;
        drain(100);
        check("t3_one_xfer", n_xfer, 1);

        // Zero-length kernel, relaunch in its done cycle.
        clear_logs();
        n0 = n_req_cyc;
        launch(2, 32'h500, 0);
        step();
        step();
        launch(2, 32'h600, 1);
        step();
        check("t4_done2", warp_done[2], 1);
        check("t4_relaunch_ready", launch_ready, 1);
        check("t4_no_fetch", n_req_cyc, n0);
        drain(100);
        check("t4_relaunch_done", n_done[2], 2);

        // Randomized traffic, including pc wrap.
        gnt_pct = 60;
        rdy_pct = 70;
        rv_max  = 3;
        repeat (3000) begin
            if (!l_valid && $urandom_range(9) < 3) begin
                if ($urandom_range(3) == 0)
                    launch($urandom_range(NW - 1), 32'hFFFF_FFF8, $urandom_range(5));
                else
                    launch($urandom_range(NW - 1), $urandom & 32'hFFFF_FFFC,
                           $urandom_range(5));
            end
            step();
        end
        l_valid = 1'b0;
        drain(2000);

        // Spurious return with nothing outstanding.
        gnt_pct = 100;
        rdy_pct = 100;
        inj_rv  = 1'b1;
        step();
        inj_rv  = 1'b0;
        repeat (4) step();
        check("t5_err_sticky", err_spurious, 1);
        check("t5_no_exec", lane_execute, 0);
        do_reset();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
